// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and edge-detect active-low keys, plus all-held combo detect
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COMBO_CYCLES    = 100000
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_BTN-1:0] Key_n,
    output logic [N_BTN-1:0] Pressed,
    output logic [N_BTN-1:0] Press_pulse,
    output logic [N_BTN-1:0] Release_pulse,
    output logic             Combo_hold
);
    localparam int CW  = $clog2(DEBOUNCE_CYCLES);
    localparam int CCW = $clog2(COMBO_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CCW-1:0] CCNT_MAX = CCW'(COMBO_CYCLES);

    logic [N_BTN-1:0] sync1, sync2, change, pressed_nxt;
    logic [CW-1:0]    cnt [N_BTN];
    logic [CCW-1:0]   ccnt;

    // sync stages keep raw key polarity, so 1 is the released state
    always_comb begin
        change = '0;
        for (int j = 0; j < N_BTN; j++)
            change[j] = (~sync2[j] != Pressed[j]) && (cnt[j] == CNT_MAX);
        pressed_nxt = Pressed ^ change;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync1         <= '1;
            sync2         <= '1;
            Pressed       <= '0;
            Press_pulse   <= '0;
            Release_pulse <= '0;
            for (int j = 0; j < N_BTN; j++)
                cnt[j] <= '0;
            ccnt          <= '0;
            Combo_hold    <= 1'b0;
        end else begin
            sync1         <= Key_n;
            sync2         <= sync1;
            for (int j = 0; j < N_BTN; j++)
                cnt[j] <= ((~sync2[j] == Pressed[j]) || change[j]) ? '0 : cnt[j] + 1'b1;
            Pressed       <= pressed_nxt;
            Press_pulse   <= change & pressed_nxt;
            Release_pulse <= change & Pressed;
            ccnt          <= !(&Pressed) ? '0 : (ccnt == CCNT_MAX) ? ccnt : ccnt + 1'b1;
            // a release landing this edge drops the combo together with Pressed
            Combo_hold    <= (&Pressed) && (&pressed_nxt) && (ccnt == CCNT_MAX);
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, COMBO_CYCLES=8
module tb_button_conditioner;
    typedef struct packed {
        logic [1:0] p;
        logic [1:0] pp;
        logic [1:0] rp;
        logic       c;
    } exp_t;

    logic       Clk;
    logic       Reset_n;
    logic [1:0] Key_n;
    logic [1:0] Pressed, Press_pulse, Release_pulse;
    logic       Combo_hold;
    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;

    button_conditioner #(.N_BTN(2), .DEBOUNCE_CYCLES(4), .COMBO_CYCLES(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Key_n(Key_n), .Pressed(Pressed),
        .Press_pulse(Press_pulse), .Release_pulse(Release_pulse), .Combo_hold(Combo_hold)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t mk(input logic [1:0] p, input logic [1:0] pp, input logic [1:0] rp, input logic c);
        mk.p = p; mk.pp = pp; mk.rp = rp; mk.c = c;
    endfunction

    function automatic exp_t observed();
        return mk(Pressed, Press_pulse, Release_pulse, Combo_hold);
    endfunction

    // drive one cycle of stimulus, queue its expected outputs, sample after the edge
    task automatic cyc(input logic [1:0] key, input logic rst_n, input exp_t e);
        sb.push_back(e);
        Key_n = key;
        Reset_n = rst_n;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e, got;
        for (int i = 0; i < 22; i++) begin
            cyc(2'b11, i >= 2, mk(2'b00, 2'b00, 2'b00, 1'b0));
            got = observed();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset[%0d] got %b expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_press;
        exp_t e, got;
        for (int i = 0; i < 12; i++) begin
            cyc(2'b10, 1'b1, mk(i >= 5 ? 2'b01 : 2'b00, i == 5 ? 2'b01 : 2'b00, 2'b00, 1'b0));
            got = observed();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL press[%0d] got %b expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_release;
        exp_t e, got;
        for (int i = 0; i < 12; i++) begin
            cyc(2'b11, 1'b1, mk(i >= 5 ? 2'b00 : 2'b01, 2'b00, i == 5 ? 2'b01 : 2'b00, 1'b0));
            got = observed();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL release[%0d] got %b expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_bounce;
        exp_t e, got;
        logic [7:0] bounce;
        bounce = 8'b11001100;
        for (int i = 0; i < 20; i++) begin
            cyc({1'b1, i < 8 ? bounce[i] : 1'b0}, 1'b1,
                mk(i >= 13 ? 2'b01 : 2'b00, i == 13 ? 2'b01 : 2'b00, 2'b00, 1'b0));
            got = observed();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL bounce[%0d] got %b expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_combo;
        exp_t e, got;
        logic [1:0] key, p;
        for (int i = 0; i < 34; i++) begin
            key = i < 17 ? 2'b00 : i < 26 ? 2'b10 : 2'b11;
            p   = i < 5 ? 2'b00 : i < 22 ? 2'b11 : i < 31 ? 2'b01 : 2'b00;
            cyc(key, 1'b1, mk(p, i == 5 ? 2'b11 : 2'b00,
                              i == 22 ? 2'b10 : i == 31 ? 2'b01 : 2'b00, i >= 14 && i < 22));
            got = observed();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL combo[%0d] got %b expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e, got;
        for (int i = 0; i < 15; i++) begin
            cyc(2'b10, i != 5, mk(i >= 11 ? 2'b01 : 2'b00, i == 11 ? 2'b01 : 2'b00, 2'b00, 1'b0));
            got = observed();
            e = sb.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid[%0d] got %b expected %b", i, got, e);
            end
        end
    endtask

    initial begin
        Key_n = 2'b11;
        Reset_n = 1'b0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_release();
        test_combo();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
